// File: rtl/mcap_trig_pack.sv
// mcap_trig_pack: N-channel logic-capture engine.
// Samples NCH inputs at Fclk/(div_value+1), waits for a trigger (immediate,
// pattern, rising or falling edge), packs WW samples per channel into WW-bit
// words (earliest sample at the MSB) and pushes them through a one-block flush
// buffer into a 2^FIFO_AW-word FIFO that is popped with rd_pulse.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   sig_in                channel inputs (bit i = channel i)
//   enable, div_value     sample-rate divider control
//   cycles_value, trig_*  session config, latched on start_pulse
//   start/abort_pulse     session control
//   rd_pulse, fifo_clr_pulse  FIFO pop / clear
//   data_valid, data_word popped word, one cycle after rd_pulse
//   busy..full, level, irq    status
module mcap_trig_pack #(
  parameter int NCH     = 4,
  parameter int WW      = 16,
  parameter int FIFO_AW = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     sig_in,
  input  logic               enable,
  input  logic [31:0]        div_value,
  input  logic [31:0]        cycles_value,
  input  logic [1:0]         trig_mode,
  input  logic [NCH-1:0]     trig_mask,
  input  logic [NCH-1:0]     trig_pattern,
  input  logic               start_pulse,
  input  logic               abort_pulse,
  input  logic               rd_pulse,
  input  logic               fifo_clr_pulse,
  output logic               data_valid,
  output logic [WW-1:0]      data_word,
  output logic               busy,
  output logic               armed,
  output logic               done,
  output logic               overrun,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   level,
  output logic               irq
);
  localparam int SW    = $clog2(WW + 1);
  localparam int FLW   = $clog2(NCH + 1);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [31:0]         dcnt_q, dcnt_d;
  logic [31:0]         rem_q, rem_d;
  logic [1:0]          mode_q, mode_d;
  logic [NCH-1:0]      mask_q, mask_d, pat_q, pat_d, prev_q, prev_d;
  logic                pvld_q, pvld_d;
  logic [SW-1:0]       step_q, step_d;
  logic [FLW-1:0]      fbl_q, fbl_d;      // unwritten words left in flush buffer
  logic                busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic [FIFO_AW-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [FIFO_AW:0]    lvl_q, lvl_d;
  logic                dv_q, dv_d;
  logic [WW-1:0]       dw_q, dw_d;

  logic [WW-1:0]       sh_q  [NCH];
  logic [WW-1:0]       fb_q  [NCH];       // fb_q[0] is always the next word to write
  logic [WW-1:0]       mem   [DEPTH];
  logic [WW-1:0]       sh_nx [NCH];
  logic [WW-1:0]       blk_w [NCH];

  logic                samp, abort_act, cap, fire, fb_load, fb_wr;
  logic                fifo_we, fifo_re, full_w;
  logic [SW-1:0]       step_inc;
  logic [NCH-1:0]      masked;

  assign samp   = enable && (dcnt_q >= div_value);
  assign full_w = (lvl_q == (FIFO_AW+1)'(DEPTH));

  // A short tail block is left-aligned: stale bits above step shift out.
  always_comb begin
    step_inc = step_q + SW'(1);
    for (int i = 0; i < NCH; i++) begin
      sh_nx[i] = (sh_q[i] << 1) | WW'(sig_in[i]);
      blk_w[i] = sh_nx[i] << (SW'(WW) - step_inc);
    end
  end

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    rem_d     = rem_q;
    mode_d    = mode_q;
    mask_d    = mask_q;
    pat_d     = pat_q;
    prev_d    = prev_q;
    pvld_d    = pvld_q;
    step_d    = step_q;
    fbl_d     = fbl_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ovr_d     = ovr_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    lvl_d     = lvl_q;
    dv_d      = 1'b0;
    dw_d      = dw_q;
    cap       = 1'b0;
    fire      = 1'b0;
    fb_load   = 1'b0;
    abort_act = abort_pulse && (state_q != S_IDLE);
    masked    = sig_in & mask_q;

    if (!enable || samp) dcnt_d = '0;
    else                 dcnt_d = dcnt_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        if (start_pulse && !abort_pulse) begin
          mode_d  = trig_mode;
          mask_d  = trig_mask;
          pat_d   = trig_pattern;
          rem_d   = cycles_value;
          step_d  = '0;
          pvld_d  = 1'b0;
          done_d  = 1'b0;
          ovr_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = (cycles_value == 32'd0) ? S_DONE : S_ARM;
        end
      end
      S_ARM: begin
        if (samp && !abort_act) begin
          case (mode_q)
            2'd0: fire = 1'b1;
            2'd1: fire = (|mask_q) && (masked == (pat_q & mask_q));
            2'd2: begin
              // first edge-mode sample only primes prev_q
              fire   = pvld_q && (|(masked & ~prev_q));
              prev_d = sig_in;
              pvld_d = 1'b1;
            end
            default: begin
              fire   = pvld_q && (|(mask_q & prev_q & ~sig_in));
              prev_d = sig_in;
              pvld_d = 1'b1;
            end
          endcase
          cap = fire;
        end
      end
      S_RUN:   cap = samp && !abort_act;
      S_DRAIN: if (fbl_q == '0) state_d = S_DONE;
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    fb_wr = (fbl_q != '0) && !full_w && !abort_act;
    if (fb_wr) fbl_d = fbl_q - FLW'(1);

    if (cap) begin
      step_d = step_inc;
      rem_d  = rem_q - 32'd1;
      if (step_inc == SW'(WW) || rem_q == 32'd1) begin
        step_d = '0;
        // a new block never overwrites words still waiting in the flush buffer
        if (fbl_q != '0) ovr_d = 1'b1;
        else begin
          fb_load = 1'b1;
          fbl_d   = FLW'(NCH);
        end
      end
      state_d = (rem_q == 32'd1) ? S_DRAIN : S_RUN;
    end

    if (abort_act) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = done_q;
      fbl_d   = '0;
    end

    // clear beats a same-cycle read or write; the flush word written then is lost
    fifo_we = fb_wr && !fifo_clr_pulse;
    fifo_re = rd_pulse && (lvl_q != '0) && !fifo_clr_pulse;
    dv_d    = fifo_re;
    if (fifo_re) dw_d = mem[rp_q];
    if (fifo_clr_pulse) begin
      wp_d  = '0;
      rp_d  = '0;
      lvl_d = '0;
    end else begin
      if (fifo_we) wp_d = wp_q + FIFO_AW'(1);
      if (fifo_re) rp_d = rp_q + FIFO_AW'(1);
      if (fifo_we && !fifo_re)      lvl_d = lvl_q + (FIFO_AW+1)'(1);
      else if (!fifo_we && fifo_re) lvl_d = lvl_q - (FIFO_AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      mask_q  <= '0;
      pat_q   <= '0;
      prev_q  <= '0;
      pvld_q  <= 1'b0;
      step_q  <= '0;
      fbl_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      lvl_q   <= '0;
      dv_q    <= 1'b0;
      dw_q    <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      pat_q   <= pat_d;
      prev_q  <= prev_d;
      pvld_q  <= pvld_d;
      step_q  <= step_d;
      fbl_q   <= fbl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      lvl_q   <= lvl_d;
      dv_q    <= dv_d;
      dw_q    <= dw_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      for (int i = 0; i < NCH; i++) sh_q[i] <= sh_nx[i];
    end
    if (fb_load) begin
      for (int i = 0; i < NCH; i++) fb_q[i] <= blk_w[i];
    end else if (fb_wr) begin
      for (int i = 0; i < NCH - 1; i++) fb_q[i] <= fb_q[i+1];
    end
    if (fifo_we) mem[wp_q] <= fb_q[0];
  end

  assign busy       = busy_q;
  assign armed      = (state_q == S_ARM);
  assign done       = done_q;
  assign overrun    = ovr_q;
  assign empty      = (lvl_q == '0);
  assign full       = full_w;
  assign level      = lvl_q;
  assign irq        = (lvl_q != '0) | done_q | ovr_q;
  assign data_valid = dv_q;
  assign data_word  = dw_q;

endmodule

// File: tb/tb_mcap_trig_pack.sv
// Testbench for mcap_trig_pack: directed scenarios plus randomized traffic,
// all checked against a queue-based behavioural model of the capture engine.
module tb_mcap_trig_pack;
  localparam int NCH = 4, WW = 8, FIFO_AW = 2, DEPTH = 1 << FIFO_AW;

  logic               clk = 1'b0, rst_n = 1'b0;
  logic [NCH-1:0]     sig_in = '0;
  logic               enable = 1'b0;
  logic [31:0]        div_value = '0, cycles_value = '0;
  logic [1:0]         trig_mode = '0;
  logic [NCH-1:0]     trig_mask = '0, trig_pattern = '0;
  logic               start_pulse = 1'b0, abort_pulse = 1'b0;
  logic               rd_pulse = 1'b0, fifo_clr_pulse = 1'b0;
  logic               data_valid;
  logic [WW-1:0]      data_word;
  logic               busy, armed, done, overrun, empty, full, irq;
  logic [FIFO_AW:0]   level;

  int n_cmp = 0, n_bad = 0;

  mcap_trig_pack #(.NCH(NCH), .WW(WW), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
    .div_value(div_value), .cycles_value(cycles_value), .trig_mode(trig_mode),
    .trig_mask(trig_mask), .trig_pattern(trig_pattern), .start_pulse(start_pulse),
    .abort_pulse(abort_pulse), .rd_pulse(rd_pulse), .fifo_clr_pulse(fifo_clr_pulse),
    .data_valid(data_valid), .data_word(data_word), .busy(busy), .armed(armed),
    .done(done), .overrun(overrun), .empty(empty), .full(full), .level(level), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]    m_div = '0;
  logic [NCH-1:0] m_blk [$];
  logic [WW-1:0]  m_fq [$];
  logic [WW-1:0]  m_fifo [$];
  bit             m_busy = 0, m_arm = 0, m_cap = 0, m_drn = 0, m_fin = 0;
  bit             m_done = 0, m_ovr = 0, m_dv = 0, m_pok = 0;
  logic [WW-1:0]  m_dw = '0;
  logic [NCH-1:0] m_prev = '0, m_mask = '0, m_pat = '0;
  logic [1:0]     m_mode = '0;
  longint         m_left = 0;

  always @(posedge clk or negedge rst_n) begin : mdl
    bit          samp, ab, fw, fr, fire;
    int          pre_fq;
    logic [WW-1:0] head, w;
    if (!rst_n) begin
      m_div = '0; m_busy = 0; m_arm = 0; m_cap = 0; m_drn = 0; m_fin = 0;
      m_done = 0; m_ovr = 0; m_dv = 0; m_pok = 0; m_dw = '0;
      m_blk.delete(); m_fq.delete(); m_fifo.delete();
    end else begin
      pre_fq = m_fq.size();
      samp   = enable && (m_div >= div_value);
      ab     = abort_pulse && m_busy;
      fw     = (pre_fq > 0) && (m_fifo.size() < DEPTH) && !ab;
      fr     = rd_pulse && (m_fifo.size() > 0) && !fifo_clr_pulse;
      m_dv   = fr;
      if (fr) m_dw = m_fifo[0];
      head = fw ? m_fq[0] : '0;
      if (fifo_clr_pulse) m_fifo.delete();
      else begin
        if (fr) void'(m_fifo.pop_front());
        if (fw) m_fifo.push_back(head);
      end
      if (fw) void'(m_fq.pop_front());
      m_div = (!enable || samp) ? 32'd0 : m_div + 32'd1;

      if (!m_busy) begin
        if (start_pulse && !abort_pulse) begin
          m_mode = trig_mode; m_mask = trig_mask; m_pat = trig_pattern;
          m_left = longint'(cycles_value);
          m_done = 0; m_ovr = 0; m_busy = 1; m_pok = 0; m_blk.delete();
          if (cycles_value == 0) m_fin = 1; else m_arm = 1;
        end
      end else if (ab) begin
        m_busy = 0; m_arm = 0; m_cap = 0; m_drn = 0; m_fin = 0;
        m_fq.delete(); m_blk.delete();
      end else if (m_fin) begin
        m_fin = 0; m_busy = 0; m_done = 1;
      end else if (m_drn) begin
        if (pre_fq == 0) begin m_drn = 0; m_fin = 1; end
      end else if (samp) begin
        fire = 0;
        if (m_arm) begin
          case (m_mode)
            2'd0: fire = 1;
            2'd1: fire = (m_mask != 0) && (((sig_in ^ m_pat) & m_mask) == 0);
            default: begin
              if (m_pok) begin
                for (int c = 0; c < NCH; c++)
                  if (m_mask[c] && m_prev[c] != sig_in[c] && sig_in[c] == (m_mode == 2'd2))
                    fire = 1;
              end
              m_pok = 1; m_prev = sig_in;
            end
          endcase
        end else if (m_cap) fire = 1;
        if (fire) begin
          m_arm = 0;
          m_blk.push_back(sig_in);
          m_left--;
          if (m_blk.size() == WW || m_left == 0) begin
            if (pre_fq > 0) m_ovr = 1;
            else begin
              for (int c = 0; c < NCH; c++) begin
                w = '0;
                for (int k = 0; k < m_blk.size(); k++) w[WW-1-k] = m_blk[k][c];
                m_fq.push_back(w);
              end
            end
            m_blk.delete();
          end
          if (m_left == 0) begin m_cap = 0; m_drn = 1; end
          else m_cap = 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    logic [7:0] st_g, st_e;
    @(negedge clk);
    st_g = {busy, armed, done, overrun, empty, full, irq, data_valid};
    st_e = {m_busy, m_arm, m_done, m_ovr, (m_fifo.size() == 0), (m_fifo.size() == DEPTH),
            (m_fifo.size() != 0) || m_done || m_ovr, m_dv};
    chk("status", 32'(st_g), 32'(st_e));
    chk("level", 32'(level), 32'(m_fifo.size()));
    chk("data_word", 32'(data_word), 32'(m_dw));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin tick(); n++; end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic read_chk(input string tag, input logic [WW-1:0] exp);
    rd_pulse = 1'b1;
    tick();
    rd_pulse = 1'b0;
    chk({tag, "_dv"}, 32'(data_valid), 32'd1);
    chk(tag, 32'(data_word), 32'(exp));
  endtask

  task automatic start_cfg(input logic [1:0] md, input logic [NCH-1:0] msk, input int cyc);
    trig_mode = md; trig_mask = msk; cycles_value = 32'(cyc);
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
  endtask

  initial begin
    logic [FIFO_AW:0] lvl_save;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_status", 32'({busy, armed, done, overrun, empty, full, irq, data_valid}), 32'h08);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_dword", 32'(data_word), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b1; div_value = 32'd0;

    // full block, CH0 high
    sig_in = 4'b0001;
    start_cfg(2'd0, 4'b0000, 8);
    wait_idle(100);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_level", 32'(level), 32'd4);
    read_chk("t1_w0", 8'hFF); read_chk("t1_w1", 8'h00);
    read_chk("t1_w2", 8'h00); read_chk("t1_w3", 8'h00);

    // short tail block 1,0,1 on CH0
    sig_in = 4'b0001;
    start_cfg(2'd0, 4'b0000, 3);
    tick(); sig_in = 4'b0000;
    tick(); sig_in = 4'b0001;
    tick();
    wait_idle(100);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_irq", 32'(irq), 32'd1);
    read_chk("t2_w0", 8'hA0); read_chk("t2_w1", 8'h00);
    read_chk("t2_w2", 8'h00); read_chk("t2_w3", 8'h00);

    // rising edge on CH1
    sig_in = 4'b0000;
    start_cfg(2'd2, 4'b0010, 8);
    repeat (5) tick();
    chk("t3_armed", 32'(armed), 32'd1);
    sig_in = 4'b0010;
    wait_idle(100);
    read_chk("t3_w0", 8'h00); read_chk("t3_w1", 8'hFF);
    read_chk("t3_w2", 8'h00); read_chk("t3_w3", 8'h00);

    // FIFO saturation and dropped block
    sig_in = 4'b0101;
    start_cfg(2'd0, 4'b0000, 24);
    repeat (30) tick();
    chk("t4_overrun", 32'(overrun), 32'd1);
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_irq", 32'(irq), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    for (int b = 0; b < 2; b++) begin
      read_chk("t4_c0", 8'hFF); read_chk("t4_c1", 8'h00);
      read_chk("t4_c2", 8'hFF); read_chk("t4_c3", 8'h00);
    end
    wait_idle(100);
    chk("t4_ovr_sticky", 32'(overrun), 32'd1);

    // abort mid-run
    start_cfg(2'd0, 4'b0000, 20);
    repeat (5) tick();
    lvl_save = level;
    abort_pulse = 1'b1;
    tick();
    abort_pulse = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    repeat (5) tick();
    chk("t5_level", 32'(level), 32'(lvl_save));

    // clear together with read at level 3
    sig_in = 4'b1010;
    start_cfg(2'd0, 4'b0000, 8);
    wait_idle(100);
    read_chk("t6_w0", 8'h00);
    chk("t6_level3", 32'(level), 32'd3);
    fifo_clr_pulse = 1'b1; rd_pulse = 1'b1;
    tick();
    fifo_clr_pulse = 1'b0; rd_pulse = 1'b0;
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_dv", 32'(data_valid), 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      sig_in         = NCH'($urandom);
      enable         = ($urandom_range(0, 15) != 0);
      div_value      = 32'($urandom_range(0, 3));
      cycles_value   = 32'($urandom_range(0, 40));
      trig_mode      = 2'($urandom);
      trig_mask      = NCH'($urandom);
      trig_pattern   = NCH'($urandom);
      start_pulse    = ($urandom_range(0, 15) == 0);
      abort_pulse    = ($urandom_range(0, 149) == 0);
      rd_pulse       = ($urandom_range(0, 2) == 0);
      fifo_clr_pulse = ($urandom_range(0, 199) == 0);
      tick();
    end
    start_pulse = 1'b0; abort_pulse = 1'b0; rd_pulse = 1'b0; fifo_clr_pulse = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mcap_trig_pack.md
# mcap_trig_pack

Parametrised N-channel logic-capture engine, next generation of the four-channel 16-bit packer. It samples NCH digital inputs at Fclk/(div+1) and waits for a programmable trigger (immediate, pattern, rising or falling edge). It then packs WW consecutive samples per channel into WW-bit words and streams them into an internal synchronous FIFO read by the register bank. A one-block flush buffer lets sampling continue while a block drains, and a sticky overrun flag reports any block that is dropped.

## Interface
- NCH, 4, channel count (1..16)
- WW, 16, bits per packed word = samples per block (2..32)
- FIFO_AW, 10, FIFO depth 2^FIFO_AW words
- clk  in  1  single system clock
- rst_n  in  1  asynchronous active-low reset
- sig_in  in  NCH  channel inputs, bit i = CHi
- enable  in  1  level; divider runs while high
- div_value  in  32  Fs = Fclk/(div_value+1)
- cycles_value  in  32  samples to capture after trigger; latched at start
- trig_mode  in  2  0 immediate, 1 pattern, 2 rising edge, 3 falling edge; latched at start
- trig_mask  in  NCH  channels participating in trigger; latched at start
- trig_pattern  in  NCH  pattern for mode 1; latched at start
- start_pulse  in  1  one-cycle start; ignored while busy
- abort_pulse  in  1  one-cycle abort of the current session
- rd_pulse  in  1  pop one word
- fifo_clr_pulse  in  1  empty the FIFO
- data_valid  out  1  one-cycle strobe, data_word valid
- data_word  out  WW  popped word
- busy, armed, done, overrun, empty, full  out  1 each  status
- level  out  FIFO_AW+1  FIFO occupancy
- irq  out  1  ~empty | done | overrun

## Operation
- Divider: counter resets to 0 when enable is low; emits a one-cycle samp pulse when cnt >= div_value, then reloads 0. sig_in is taken in the samp cycle.
- FSM IDLE -> ARM -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE: start_pulse latches the config, clears done and overrun, and sets busy. If cycles == 0 -> DONE; else -> ARM.
- ARM (armed=1): evaluated on each samp.
  - Mode 0 fires on the first samp.
  - Mode 1 fires when (sig_in & mask) == (pattern & mask).
  - Mode 2 fires when any masked bit goes 0->1 versus the previous samp; mode 3 fires on any masked 1->0.
  - The first samp in ARM only loads the previous-sample register for modes 2 and 3.
  - mask == 0 in modes 1 to 3: never fires.
  - The triggering sample is capture sample 0 and counts toward cycles.
- RUN: each samp shifts sig_in[i] into shift register sh[i] at the LSB, so the earliest sample ends up at the MSB. It increments step and decrements remaining.
  - When step reaches WW, or remaining reaches 0 with step != 0, the block is copied to the flush buffer. A short tail block is shifted left by WW-step, zero-filled.
  - If the flush buffer still holds unwritten words, the new block is dropped and overrun is set. remaining still counts down.
  - When remaining reaches 0 -> DRAIN.
- Flush buffer: writes words CH0..CH(NCH-1), one per cycle while FIFO is not full, and stalls while full. It runs concurrently with ARM and RUN.
- DRAIN: waits for the flush buffer to empty, then goes to DONE.
- DONE: one cycle. Sets sticky done, clears busy, goes to IDLE.
- abort_pulse, in any state except IDLE: next state IDLE. Discards the partial block and unwritten flush words, clears busy, does not set done. FIFO contents are kept.
- FIFO: wr and rd in the same cycle both take effect and level is unchanged. fifo_clr_pulse zeroes pointers and count next cycle and wins over a same-cycle write or read. Clearing during RUN does not stop capture.
- Read: rd_pulse with ~empty pops; data_valid and data_word follow one cycle later. rd_pulse while empty is ignored, with no strobe.

## Timing
- Reset values: busy=armed=done=overrun=data_valid=0, data_word=0, empty=1, full=0, level=0, irq=0, FSM IDLE.
- start to ARM: 1 cycle. First FIFO write: 1 cycle after the block-completing samp.
- Full block: NCH write cycles minimum. Sustained rate without overrun needs WW*(div+1) >= NCH plus stall cycles.
- status, level and irq are registered or derived from registers.
- Simultaneous events:
  - start with abort: abort wins.
  - start in the DONE cycle: ignored.
  - samp on the same cycle as abort: the sample is discarded.

## Test plan
- NCH=4, WW=8, div=0, mode 0, cycles=8, sig_in CH0 fixed 1, CH1..3 0 -> 4 words 0xFF,0x00,0x00,0x00; done=1; level=4.
- cycles=3, CH0 pattern 1,0,1 -> CH0 word 0xA0 (tail left-aligned); done and irq set.
- Mode 2, mask=0b0010, CH1 low for 5 samples then high -> armed stays 1 until the edge; the first captured CH1 bit (MSB) is 1.
- FIFO_AW=2 with reads held off, cycles=24 -> FIFO fills to 4, flush stalls, next block dropped; overrun=1, full=1, irq=1.
- Abort mid-RUN after 5 samples -> busy=0 next cycle, done=0, no new words written.
- fifo_clr_pulse with a rd_pulse in the same cycle, level=3 -> level=0, empty=1, no data_valid.
